sha256_block_scheduler: RTL

//  Sequences per-block hashing. Fetches the 16 padded message words of each 512-bit block from the

---
 rtl/sha256_pkg.sv | 27 ++
 rtl/sha256_wexp_buf.sv | 29 ++
 rtl/sha256_block_scheduler.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared types and SHA-256 schedule helpers for the block scheduler.
package sha256_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXPAND,
    WAIT_COMP,
    DONE
  } sched_state_t;

  localparam int WORDS_PER_BLOCK = 16;
  localparam int ROUNDS          = 64;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_wexp_buf.sv
// 16x32 message-schedule window: four asynchronous read ports, one synchronous write port.
module sha256_wexp_buf (
  input  logic        clk,
  input  logic        we,
  input  logic [3:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [3:0]  raddr_a,
  input  logic [3:0]  raddr_b,
  input  logic [3:0]  raddr_c,
  input  logic [3:0]  raddr_d,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b,
  output logic [31:0] rdata_c,
  output logic [31:0] rdata_d
);

  logic [31:0] mem [16];

  // Data words carry no reset; every entry is written before it is read in a block.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];
  assign rdata_c = mem[raddr_c];
  assign rdata_d = mem[raddr_d];

endmodule

// File: rtl/sha256_block_scheduler.sv
// Per-block fetch / W expansion sequencer for SHA-256.
// Optional SCHED_PERF_CNT_EN adds a saturating busy-cycle counter output cycle_cnt.
module sha256_block_scheduler
  import sha256_pkg::*;
#(
  parameter int MAX_BLOCKS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  num_blocks,
  input  logic [31:0] word_data,
  input  logic        word_valid,
  output logic        req_word,
  output logic [7:0]  word_address,
  output logic [3:0]  current_block,
  output logic        busy,
  output logic [31:0] w_data,
  output logic        w_valid,
  input  logic        w_ready,
  output logic [5:0]  w_round,
  input  logic        comp_done,
  output logic        all_done,
`ifdef SCHED_PERF_CNT_EN
  output logic [15:0] cycle_cnt,
`endif
  output logic        err
);

  sched_state_t state;
  logic [3:0]   word_idx;
  logic [5:0]   t;
  logic [3:0]   nb_last;

  logic [31:0] buf_cur, buf_m2, buf_m7, buf_m15;
  logic [31:0] w_calc;
  logic        buf_we;
  logic [3:0]  buf_waddr;
  logic [31:0] buf_wdata;
  logic        clamp;
  logic        fetch_acc;
  logic        w_acc;

  assign clamp = 32'(num_blocks) >= 32'(MAX_BLOCKS);

  assign req_word     = (state == FETCH);
  assign w_valid      = (state == EXPAND);
  assign busy         = (state != IDLE);
  assign all_done     = (state == DONE);
  assign word_address = {current_block[1:0], word_idx, 2'b00};
  assign w_round      = t;

  assign fetch_acc = req_word && word_valid;
  assign w_acc     = w_valid && w_ready;

  // Slot t&15 still holds W[t-16] until it is overwritten with W[t] on acceptance.
  assign w_calc = (t[5:4] == 2'b00) ? buf_cur
                                    : sig1(buf_m2) + buf_m7 + sig0(buf_m15) + buf_cur;
  assign w_data = w_valid ? w_calc : 32'd0;

  assign buf_we    = fetch_acc || (w_acc && (t[5:4] != 2'b00));
  assign buf_waddr = fetch_acc ? word_idx : t[3:0];
  assign buf_wdata = fetch_acc ? word_data : w_calc;

  sha256_wexp_buf u_buf (
    .clk     (clk),
    .we      (buf_we),
    .waddr   (buf_waddr),
    .wdata   (buf_wdata),
    .raddr_a (t[3:0]),
    .raddr_b (t[3:0] - 4'd2),
    .raddr_c (t[3:0] - 4'd7),
    .raddr_d (t[3:0] - 4'd15),
    .rdata_a (buf_cur),
    .rdata_b (buf_m2),
    .rdata_c (buf_m7),
    .rdata_d (buf_m15)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      word_idx      <= 4'd0;
      t             <= 6'd0;
      current_block <= 4'd0;
      nb_last       <= 4'd0;
      err           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state         <= FETCH;
            nb_last       <= clamp ? 4'(MAX_BLOCKS - 1) : num_blocks;
            err           <= clamp;
            word_idx      <= 4'd0;
            t             <= 6'd0;
            current_block <= 4'd0;
          end
        end
        FETCH: begin
          if (word_valid) begin
            if (word_idx == 4'(WORDS_PER_BLOCK - 1)) begin
              state    <= EXPAND;
              word_idx <= 4'd0;
            end else begin
              word_idx <= word_idx + 4'd1;
            end
          end
        end
        EXPAND: begin
          if (w_ready) begin
            if (t == 6'(ROUNDS - 1)) begin
              state <= WAIT_COMP;
              t     <= 6'd0;
            end else begin
              t <= t + 6'd1;
            end
          end
        end
        WAIT_COMP: begin
          if (comp_done) begin
            if (current_block == nb_last) begin
              state <= DONE;
            end else begin
              current_block <= current_block + 4'd1;
              word_idx      <= 4'd0;
              t             <= 6'd0;
              state         <= FETCH;
            end
          end
        end
        DONE: begin
          state         <= IDLE;
          current_block <= 4'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SCHED_PERF_CNT_EN
  // Value survives DONE so software can read the run length until the next start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_cnt <= 16'd0;
    end else if (state == IDLE) begin
      if (start) cycle_cnt <= 16'd0;
    end else if (cycle_cnt != 16'hFFFF) begin
      cycle_cnt <= cycle_cnt + 16'd1;
    end
  end
`endif

endmodule
